// File: rtl/instr_encoder.sv
// Program-loader front end: packs opcode/register/literal fields into a 16-bit instruction word
// and writes it to program memory at an auto-incrementing address; reserved opcodes are counted.
module instr_encoder #(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned PROGRAM_DataWidth = 16,
  parameter int unsigned NumOpCodeBits     = 5,
  parameter int unsigned ParamBits         = 8,
  parameter int unsigned SEL_WIDTH         = 2,
  parameter int unsigned ERR_CNT_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NumOpCodeBits-1:0]     in_opcode,
  input  logic [SEL_WIDTH-1:0]         in_op1,
  input  logic [SEL_WIDTH-1:0]         in_op2,
  input  logic [ParamBits-1:0]         in_literal,
  output logic                         prog_wr_en,
  output logic [PC_WIDTH-1:0]          prog_wr_adr,
  output logic [PROGRAM_DataWidth-1:0] prog_wr_data,
  output logic [PC_WIDTH-1:0]          wr_ptr,
  output logic                         full,
  output logic                         err,
  output logic [ERR_CNT_WIDTH-1:0]     err_cnt
);

  localparam int unsigned OpMsb  = PROGRAM_DataWidth - 1;
  localparam int unsigned Op1Lsb = 8;
  localparam int unsigned Op2Lsb = 3;

  localparam logic [NumOpCodeBits-1:0] OpNop  = NumOpCodeBits'(5'b00000);
  localparam logic [NumOpCodeBits-1:0] OpAdd  = NumOpCodeBits'(5'b00001);
  localparam logic [NumOpCodeBits-1:0] OpSub  = NumOpCodeBits'(5'b00010);
  localparam logic [NumOpCodeBits-1:0] OpAnd  = NumOpCodeBits'(5'b00011);
  localparam logic [NumOpCodeBits-1:0] OpOr   = NumOpCodeBits'(5'b00100);
  localparam logic [NumOpCodeBits-1:0] OpNot  = NumOpCodeBits'(5'b00101);
  localparam logic [NumOpCodeBits-1:0] OpXor  = NumOpCodeBits'(5'b00110);
  localparam logic [NumOpCodeBits-1:0] OpShl  = NumOpCodeBits'(5'b00111);
  localparam logic [NumOpCodeBits-1:0] OpShr  = NumOpCodeBits'(5'b01000);
  localparam logic [NumOpCodeBits-1:0] OpVal  = NumOpCodeBits'(5'b01001);
  localparam logic [NumOpCodeBits-1:0] OpGoto = NumOpCodeBits'(5'b10000);
  localparam logic [NumOpCodeBits-1:0] OpIfz  = NumOpCodeBits'(5'b10001);
  localparam logic [NumOpCodeBits-1:0] OpIfnz = NumOpCodeBits'(5'b10010);
  localparam logic [NumOpCodeBits-1:0] OpIfeq = NumOpCodeBits'(5'b10011);
  localparam logic [NumOpCodeBits-1:0] OpIfst = NumOpCodeBits'(5'b10100);
  localparam logic [NumOpCodeBits-1:0] OpIfgt = NumOpCodeBits'(5'b10101);

  typedef enum logic [1:0] {StIdle, StEnc, StWr} state_e;

  state_e                         state_q, state_d;
  logic [NumOpCodeBits-1:0]       op_q, op_d;
  logic [SEL_WIDTH-1:0]           op1_q, op1_d, op2_q, op2_d;
  logic [ParamBits-1:0]           lit_q, lit_d;
  logic [PC_WIDTH-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PC_WIDTH-1:0]            adr_q, adr_d;
  logic [PROGRAM_DataWidth-1:0]   data_q, data_d;
  logic                           full_q, full_d;
  logic                           err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0]       err_cnt_q, err_cnt_d;

  logic [PROGRAM_DataWidth-1:0]   word;
  logic                           legal;

  // Field placement by opcode class; anything not listed is reserved.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (op_q)
      OpNop: ;
      OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
        word[OpMsb -: NumOpCodeBits] = op_q;
        word[Op1Lsb +: SEL_WIDTH]    = op1_q;
        word[Op2Lsb +: SEL_WIDTH]    = op2_q;
      end
      OpNot, OpShl, OpShr: begin
        word[OpMsb -: NumOpCodeBits] = op_q;
        word[Op1Lsb +: SEL_WIDTH]    = op1_q;
      end
      OpVal: begin
        word[OpMsb -: NumOpCodeBits] = op_q;
        word[Op1Lsb +: SEL_WIDTH]    = op1_q;
        word[0 +: ParamBits]         = lit_q;
      end
      OpGoto, OpIfz, OpIfnz, OpIfeq, OpIfst, OpIfgt: begin
        word[OpMsb -: NumOpCodeBits] = op_q;
        word[0 +: ParamBits]         = lit_q;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    lit_d     = lit_q;
    wr_ptr_d  = wr_ptr_q;
    adr_d     = adr_q;
    data_d    = data_q;
    full_d    = full_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      state_d   = StIdle;
      wr_ptr_d  = '0;
      full_d    = 1'b0;
      err_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            op_d    = in_opcode;
            op1_d   = in_op1;
            op2_d   = in_op2;
            lit_d   = in_literal;
            state_d = StEnc;
          end
        end
        StEnc: begin
          if (legal) begin
            data_d  = word;
            adr_d   = wr_ptr_q;
            state_d = StWr;
          end else begin
            err_d   = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            state_d = StIdle;
          end
        end
        StWr: begin
          // The last address is written once; the pointer then parks there.
          if (wr_ptr_q == '1) full_d = 1'b1;
          else                wr_ptr_d = wr_ptr_q + PC_WIDTH'(1);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      lit_q     <= '0;
      wr_ptr_q  <= '0;
      adr_q     <= '0;
      data_q    <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      lit_q     <= lit_d;
      wr_ptr_q  <= wr_ptr_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      full_q    <= full_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // clr in the write cycle must kill the strobe in that same cycle.
  assign prog_wr_en   = (state_q == StWr) && !clr;
  assign prog_wr_adr  = adr_q;
  assign prog_wr_data = data_q;
  assign in_ready     = (state_q == StIdle) && !full_q;
  assign wr_ptr       = wr_ptr_q;
  assign full         = full_q;
  assign err          = err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a vector table for encodings, plus hand sequences for
// counter saturation, memory-full, clr during a write and reset during encode.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n, clr, in_valid, in_ready;
  logic [4:0]  in_opcode;
  logic [1:0]  in_op1, in_op2;
  logic [7:0]  in_literal;
  logic        prog_wr_en, full, err;
  logic [7:0]  prog_wr_adr, wr_ptr;
  logic [15:0] prog_wr_data;
  logic [3:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  instr_encoder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .in_literal   (in_literal),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_adr  (prog_wr_adr),
    .prog_wr_data (prog_wr_data),
    .wr_ptr       (wr_ptr),
    .full         (full),
    .err          (err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic [7:0]  lit;
    logic        legal;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one field set for one accepted edge; returns one step into ENC.
  task automatic send(input logic [4:0] op, input logic [1:0] o1, input logic [1:0] o2,
                      input logic [7:0] lit);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    in_opcode  = op;
    in_op1     = o1;
    in_op2     = o2;
    in_literal = lit;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_ptr;
    logic [3:0] exp_cnt;
    int         seen;

    vecs[0]  = '{5'b00000, 2'd3, 2'd3, 8'hFF, 1'b1, 16'h0000}; // NOP
    vecs[1]  = '{5'b00001, 2'd2, 2'd2, 8'h55, 1'b1, 16'h0A10}; // ADD
    vecs[2]  = '{5'b00001, 2'd1, 2'd2, 8'h00, 1'b1, 16'h0910}; // ADD
    vecs[3]  = '{5'b00010, 2'd3, 2'd1, 8'hFF, 1'b1, 16'h1308}; // SUB
    vecs[4]  = '{5'b00011, 2'd2, 2'd1, 8'h00, 1'b1, 16'h1A08}; // AND
    vecs[5]  = '{5'b00100, 2'd1, 2'd1, 8'h00, 1'b1, 16'h2108}; // OR
    vecs[6]  = '{5'b00110, 2'd0, 2'd3, 8'h00, 1'b1, 16'h3018}; // XOR
    vecs[7]  = '{5'b00101, 2'd2, 2'd3, 8'h77, 1'b1, 16'h2A00}; // NOT
    vecs[8]  = '{5'b00111, 2'd3, 2'd0, 8'h12, 1'b1, 16'h3B00}; // SHL
    vecs[9]  = '{5'b01000, 2'd1, 2'd3, 8'h00, 1'b1, 16'h4100}; // SHR
    vecs[10] = '{5'b01001, 2'd3, 2'd1, 8'hA5, 1'b1, 16'h4BA5}; // VAL
    vecs[11] = '{5'b10000, 2'd3, 2'd3, 8'h3F, 1'b1, 16'h803F}; // GOTO
    vecs[12] = '{5'b10001, 2'd0, 2'd0, 8'h01, 1'b1, 16'h8801}; // IFZ
    vecs[13] = '{5'b10101, 2'd1, 2'd2, 8'hC3, 1'b1, 16'hA8C3}; // IFGT
    vecs[14] = '{5'b01010, 2'd1, 2'd1, 8'h11, 1'b0, 16'h0000}; // reserved
    vecs[15] = '{5'b01111, 2'd1, 2'd1, 8'h11, 1'b0, 16'h0000};
    vecs[16] = '{5'b10110, 2'd1, 2'd1, 8'h11, 1'b0, 16'h0000};
    vecs[17] = '{5'b11111, 2'd1, 2'd1, 8'h11, 1'b0, 16'h0000};

    reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_op1 = '0; in_op2 = '0; in_literal = '0;
    #12 reset_n = 1'b1;
    tick();

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en", 32'(prog_wr_en), 32'd0);
    chk("rst_adr", 32'(prog_wr_adr), 32'd0);
    chk("rst_data", 32'(prog_wr_data), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Encoding table
    exp_ptr = 8'd0;
    exp_cnt = 4'd0;
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].op1, vecs[i].op2, vecs[i].lit);
      chk("enc_ready_low", 32'(in_ready), 32'd0);
      chk("enc_no_wr", 32'(prog_wr_en), 32'd0);
      tick();
      if (vecs[i].legal) begin
        chk("wr_en", 32'(prog_wr_en), 32'd1);
        chk("wr_adr", 32'(prog_wr_adr), 32'(exp_ptr));
        chk("wr_data", 32'(prog_wr_data), 32'(vecs[i].word));
        chk("wr_ready_low", 32'(in_ready), 32'd0);
        chk("wr_no_err", 32'(err), 32'd0);
        exp_ptr++;
        tick();
        chk("post_wr_en", 32'(prog_wr_en), 32'd0);
        chk("post_wr_ptr", 32'(wr_ptr), 32'(exp_ptr));
        chk("post_wr_data_hold", 32'(prog_wr_data), 32'(vecs[i].word));
        chk("post_wr_ready", 32'(in_ready), 32'd1);
      end else begin
        exp_cnt++;
        chk("rsv_err", 32'(err), 32'd1);
        chk("rsv_no_wr", 32'(prog_wr_en), 32'd0);
        chk("rsv_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        chk("rsv_wr_ptr", 32'(wr_ptr), 32'(exp_ptr));
        chk("rsv_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rsv_err_pulse", 32'(err), 32'd0);
      end
    end

    // Saturation of the reject counter
    do_clr();
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_wr_ptr", 32'(wr_ptr), 32'd0);
    exp_cnt = 4'd0;
    for (int k = 0; k < 17; k++) begin
      send(5'b01100, 2'd0, 2'd0, 8'd0);
      tick();
      if (exp_cnt != 4'hF) exp_cnt++;
      chk("sat_err_cnt", 32'(err_cnt), 32'(exp_cnt));
    end
    chk("sat_final", 32'(err_cnt), 32'hF);

    // Fill memory to the last address
    do_clr();
    for (int k = 0; k < 255; k++) begin
      send(5'b00000, 2'd0, 2'd0, 8'd0);
      tick();
      tick();
    end
    chk("fill_ptr", 32'(wr_ptr), 32'hFF);
    chk("fill_not_full", 32'(full), 32'd0);
    send(5'b00101, 2'd2, 2'd0, 8'd0);
    tick();
    chk("last_wr_en", 32'(prog_wr_en), 32'd1);
    chk("last_adr", 32'(prog_wr_adr), 32'hFF);
    chk("last_data", 32'(prog_wr_data), 32'h2A00);
    tick();
    chk("full_set", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_ptr_hold", 32'(wr_ptr), 32'hFF);
    in_opcode = 5'b00001;
    in_valid  = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (prog_wr_en) seen++;
    end
    in_valid = 1'b0;
    chk("full_ignore_wr", 32'(seen), 32'd0);
    chk("full_ignore_ptr", 32'(wr_ptr), 32'hFF);
    chk("full_still", 32'(full), 32'd1);

    // clr during the write cycle
    do_clr();
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    send(5'b01011, 2'd0, 2'd0, 8'd0);
    tick();
    send(5'b00001, 2'd1, 2'd1, 8'd0);
    tick();
    send(5'b00001, 2'd1, 2'd1, 8'd0);
    tick();
    chk("pre_clr_wr_en", 32'(prog_wr_en), 32'd1);
    chk("pre_clr_err_cnt", 32'(err_cnt), 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_kills_wr", 32'(prog_wr_en), 32'd0);
    tick();
    clr = 1'b0;
    chk("clr_wr_ptr0", 32'(wr_ptr), 32'd0);
    chk("clr_full0", 32'(full), 32'd0);
    chk("clr_cnt0", 32'(err_cnt), 32'd0);
    chk("clr_ready1", 32'(in_ready), 32'd1);
    chk("clr_no_wr", 32'(prog_wr_en), 32'd0);

    // Asynchronous reset during encode
    send(5'b01001, 2'd3, 2'd0, 8'hA5);
    tick();
    tick();
    chk("pre_rst_ptr", 32'(wr_ptr), 32'd1);
    send(5'b10000, 2'd0, 2'd0, 8'h3F);
    reset_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(prog_wr_en), 32'd0);
    chk("arst_ptr", 32'(wr_ptr), 32'd0);
    chk("arst_data", 32'(prog_wr_data), 32'd0);
    chk("arst_adr", 32'(prog_wr_adr), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    #2 reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (prog_wr_en) seen++;
    end
    chk("arst_dropped", 32'(seen), 32'd0);
    send(5'b00001, 2'd2, 2'd2, 8'd0);
    tick();
    chk("arst_again_wr", 32'(prog_wr_en), 32'd1);
    chk("arst_again_adr", 32'(prog_wr_adr), 32'd0);
    chk("arst_again_data", 32'(prog_wr_data), 32'h0A10);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
